// File: rtl/clz_pkg.sv
// -----------------------------------------------------------------------------
// clz_pkg
// Shared widths, the scan state type and the stage-width helper for the
// iterative count-leading-zeros unit (clz_unit, clz_stage).
//   DATA_W : operand / normalized result width
//   CNT_W  : count width (0..DATA_W inclusive)
//   STEPS  : number of power-of-two scan stages (16, 8, 4, 2, 1)
// -----------------------------------------------------------------------------
package clz_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int STEPS  = 5;
  localparam int STEP_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Stage k examines the top (16 >> k) bits. Step values past the last stage
  // give width 0, which makes the stage a pass-through.
  function automatic logic [CNT_W-1:0] stage_width(input logic [STEP_W-1:0] step);
    logic [CNT_W-1:0] w;
    w = CNT_W'(16) >> step;
    return w;
  endfunction

endpackage

// File: rtl/clz_stage.sv
// -----------------------------------------------------------------------------
// clz_stage
// One combinational power-of-two normalization stage. If the top `width` bits
// of `work` are all zero, both `work` and `orig` are shifted left by `width`
// (zero fill); otherwise both pass through unchanged.
// Ports:
//   work    in  DATA_W  scan value (possibly inverted operand)
//   orig    in  DATA_W  original operand, shifted in lockstep with work
//   width   in  CNT_W   stage width in bits (16, 8, 4, 2, 1; 0 = pass)
//   zero    out 1       top `width` bits of work are zero
//   work_sh out DATA_W  work after the conditional shift
//   orig_sh out DATA_W  orig after the conditional shift
// -----------------------------------------------------------------------------
module clz_stage
  import clz_pkg::*;
(
  input  logic [DATA_W-1:0] work,
  input  logic [DATA_W-1:0] orig,
  input  logic [CNT_W-1:0]  width,
  output logic              zero,
  output logic [DATA_W-1:0] work_sh,
  output logic [DATA_W-1:0] orig_sh
);

  logic [DATA_W-1:0] mask;

  // A variable-width part-select is not legal, so the top `width` bits are
  // selected with a mask built from an all-ones vector shifted right.
  always_comb begin
    mask    = ~({DATA_W{1'b1}} >> width);
    zero    = ((work & mask) == '0);
    work_sh = zero ? (work << width) : work;
    orig_sh = zero ? (orig << width) : orig;
  end

endmodule

// File: rtl/clz_unit.sv
// -----------------------------------------------------------------------------
// clz_unit
// Iterative count-leading-zeros unit. An accepted start captures the operand;
// five single-cycle stages (16, 8, 4, 2, 1) then normalize it, and the last
// stage also produces the count, the normalized operand and a one-cycle done.
// Fixed, data-independent latency: done is seen 5 cycles after acceptance.
//
// Optional feature (macro CLZ_CLO_EN):
//   defined   -> `clo` input exists; clo=1 counts leading ones by inverting
//                the scan copy at capture; norm still shifts the original.
//   undefined -> no `clo` port, behaves as clo=0.
//
// Ports:
//   clk     in  1       clock, rising edge
//   rst     in  1       asynchronous, active-high reset
//   start   in  1       request, sampled only while not busy
//   clo     in  1       count leading ones (CLZ_CLO_EN only)
//   operand in  32      value to scan, captured on accepted start
//   busy    out 1       scan in progress, start ignored
//   done    out 1       one-cycle pulse, count/norm valid
//   count   out 6       leading-zero (or -one) count, 0..32
//   norm    out 32      operand << count, zero-filled; 0 when count = 32
// -----------------------------------------------------------------------------
module clz_unit
  import clz_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CLZ_CLO_EN
  input  logic              clo,
`endif
  input  logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] norm
);

  state_t              state;
  state_t              state_nxt;
  logic [STEP_W-1:0]   step;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   orig;
  logic [CNT_W-1:0]    cnt;

  logic [CNT_W-1:0]    width;
  logic                zero;
  logic [DATA_W-1:0]   work_sh;
  logic [DATA_W-1:0]   orig_sh;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [DATA_W-1:0]   work_in;
  logic                accept;
  logic                last;

`ifdef CLZ_CLO_EN
  // Counting leading ones of x equals counting leading zeros of ~x.
  assign work_in = operand ^ {DATA_W{clo}};
`else
  assign work_in = operand;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (state == BUSY) && (step == STEP_W'(STEPS - 1));

  // Single stage instance, time-multiplexed across the five scan steps.
  assign width = stage_width(step);

  clz_stage u_stage (
    .work    (work),
    .orig    (orig),
    .width   (width),
    .zero    (zero),
    .work_sh (work_sh),
    .orig_sh (orig_sh)
  );

  assign cnt_nxt = cnt + (zero ? width : '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == BUSY);
  end

  // Scan registers: capture on accept, one stage per busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0;
      work <= '0;
      orig <= '0;
      cnt  <= '0;
    end else if (accept) begin
      step <= '0;
      work <= work_in;
      orig <= operand;
      cnt  <= '0;
    end else if (state == BUSY) begin
      step <= step + STEP_W'(1);
      work <= work_sh;
      orig <= orig_sh;
      cnt  <= cnt_nxt;
    end
  end

  // Result registers. After the width-1 stage a nonzero work value always has
  // its MSB set, so a clear MSB means the scan value was all zeros: count
  // becomes 32 and the normalized operand is defined as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      count <= '0;
      norm  <= '0;
    end else begin
      done <= last;
      if (last) begin
        count <= cnt_nxt + CNT_W'(!work_sh[DATA_W-1]);
        norm  <= work_sh[DATA_W-1] ? orig_sh : '0;
      end
    end
  end

endmodule

// File: tb/tb_clz_unit.sv
// -----------------------------------------------------------------------------
// tb_clz_unit
// Scoreboard bench for clz_unit: stimulus pushes the expected count/norm pair,
// a monitor pops and compares whenever done is presented.
// -----------------------------------------------------------------------------
module tb_clz_unit;
  import clz_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clo;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] norm;

  always #5 clk = ~clk;

  clz_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef CLZ_CLO_EN
    .clo     (clo),
`endif
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .norm    (norm)
  );

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got count=%0d, expected no result", count);
      end else begin
        e = sb.pop_front();
        check("count", 32'(count), 32'(e.c));
        check("norm", norm, e.n);
      end
    end
  end

  // Drive a request at the current negedge; returns at the negedge after the
  // accepting edge with operand/clo scrambled to prove they are not re-read.
  task automatic launch(input logic [31:0] op, input logic c,
                        input logic [5:0] ec, input logic [31:0] en, input bit push);
    exp_t e;
    start   = 1'b1;
    operand = op;
    clo     = c;
    if (push) begin
      e.c = ec;
      e.n = en;
      sb.push_back(e);
    end
    @(negedge clk);
    start   = 1'b0;
    operand = $urandom;
    clo     = ~c;
  endtask

  // Check busy for five cycles, then the done cycle. Returns in the done cycle
  // so a following launch lands there. inject pulses a stray start mid-scan.
  task automatic finish_scan(input bit inject);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("done_low_c%0d", i), 32'(done), 32'd0);
      if (inject && i == 2) begin
        start   = 1'b1;
        operand = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_end", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    clo     = 1'b0;
    operand = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_norm",  norm,       32'd0);

    launch(32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b1);
    finish_scan(1'b0);
    repeat (2) @(negedge clk);

    launch(32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1);
    finish_scan(1'b0);
    launch(32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 1'b1);
    finish_scan(1'b0);
    launch(32'h0001_F000, 1'b0, 6'd15, 32'hF800_0000, 1'b1);
    finish_scan(1'b0);
    @(negedge clk);

    // Stray start mid-scan must be ignored; then chain in the done cycle.
    launch(32'h0000_0F00, 1'b0, 6'd20, 32'hF000_0000, 1'b1);
    finish_scan(1'b1);
    launch(32'h00FF_0000, 1'b0, 6'd8, 32'hFF00_0000, 1'b1);
    finish_scan(1'b0);
    @(negedge clk);

    // Abort during step 3: outputs clear at once, no result afterwards.
    launch(32'h0000_3000, 1'b0, 6'd0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_norm",  norm,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_%0d", i), 32'(done), 32'd0);
    end

    launch(32'h0000_0100, 1'b0, 6'd23, 32'h8000_0000, 1'b1);
    finish_scan(1'b0);

`ifdef CLZ_CLO_EN
    launch(32'hFFFF_0000, 1'b1, 6'd16, 32'h0000_0000, 1'b1);
    finish_scan(1'b0);
    launch(32'hFFFF_FFFF, 1'b1, 6'd32, 32'h0000_0000, 1'b1);
    finish_scan(1'b0);
    launch(32'hFFFF_0000, 1'b0, 6'd0, 32'hFFFF_0000, 1'b1);
    finish_scan(1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
